// File: rtl/byte_calc_core.sv
// Serial-byte calculator: collects operand A, operand B and an operator byte from the UART
// receiver, shows {flag,result} on the LEDs and optionally echoes the result byte to the transmitter.
module byte_calc_core #(
    parameter int WIDTH = 4,
    parameter int ECHO  = 1
) (
    input  logic             clk12m,
    input  logic             rst_n,
    input  logic [7:0]       rx_data,
    input  logic             rx_data_rdy,
    input  logic             tx_busy,
    output logic [7:0]       tx_data,
    output logic             tx_data_rdy,
    output logic [WIDTH:0]   leds,
    output logic             err
);

    localparam logic [7:0] CH_ESC   = 8'h1B;
    localparam logic [7:0] CH_PLUS  = 8'h2B;
    localparam logic [7:0] CH_MINUS = 8'h2D;
    localparam logic [7:0] CH_AND   = 8'h26;
    localparam logic [7:0] CH_OR    = 8'h7C;

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        COMPUTE,
        TX
    } state_t;

    typedef enum logic [1:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_OR
    } op_t;

    state_t           state, state_next;
    op_t              op, op_dec;
    logic [WIDTH-1:0] a, b;
    logic [WIDTH:0]   res;
    logic             is_esc, byte_in, op_valid;
    logic             load_a, load_b, load_op, load_leds, clr_ab, err_next, tx_fire;

    assign is_esc  = rx_data_rdy && (rx_data == CH_ESC);
    assign byte_in = rx_data_rdy && !is_esc;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        op_valid = 1'b1;
        op_dec   = OP_ADD;
        case (rx_data)
            CH_PLUS:  op_dec = OP_ADD;
            CH_MINUS: op_dec = OP_SUB;
            CH_AND:   op_dec = OP_AND;
            CH_OR:    op_dec = OP_OR;
            default:  op_valid = 1'b0;
        endcase
    end

    // The subtract borrow falls out of the extra top bit of the WIDTH+1 difference.
    always_comb begin
        res = '0;
        case (op)
            OP_ADD: res = {1'b0, a} + {1'b0, b};
            OP_SUB: res = {1'b0, a} - {1'b0, b};
            OP_AND: res = {1'b0, a & b};
            OP_OR:  res = {1'b0, a | b};
            default: res = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        load_a     = 1'b0;
        load_b     = 1'b0;
        load_op    = 1'b0;
        load_leds  = 1'b0;
        clr_ab     = 1'b0;
        err_next   = 1'b0;
        tx_fire    = 1'b0;
        if (is_esc) begin
            state_next = WAIT_A;
            clr_ab     = 1'b1;
        end else begin
            case (state)
                WAIT_A: if (byte_in) begin
                    load_a     = 1'b1;
                    state_next = WAIT_B;
                end
                WAIT_B: if (byte_in) begin
                    load_b     = 1'b1;
                    state_next = WAIT_OP;
                end
                WAIT_OP: if (byte_in) begin
                    if (op_valid) begin
                        load_op    = 1'b1;
                        state_next = COMPUTE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = WAIT_A;
                    end
                end
                COMPUTE: begin
                    load_leds  = 1'b1;
                    err_next   = byte_in;
                    state_next = (ECHO != 0) ? TX : WAIT_A;
                end
                TX: begin
                    err_next = byte_in;
                    if (!tx_busy) begin
                        tx_fire    = 1'b1;
                        state_next = WAIT_A;
                    end
                end
                default: state_next = WAIT_A;
            endcase
        end
    end

    // The strobe is combinational on tx_busy so the byte is offered in the very first idle cycle.
    assign tx_data_rdy = (ECHO != 0) && tx_fire;

    always_comb begin
        tx_data = '0;
        if (tx_data_rdy) tx_data[WIDTH:0] = leds;
    end

    always_ff @(posedge clk12m or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT_A;
            op    <= OP_ADD;
            a     <= '0;
            b     <= '0;
            leds  <= '0;
            err   <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state <= state_next;
            err   <= err_next;
            if (load_op)   op   <= op_dec;
            if (load_leds) leds <= res;
            if (clr_ab) begin
                a <= '0;
                b <= '0;
            end else begin
                if (load_a) a <= rx_data[WIDTH-1:0];
                if (load_b) b <= rx_data[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_byte_calc_core.sv
// Self-checking bench for byte_calc_core (WIDTH=4): an ECHO=1 unit with a tx-byte scoreboard
// and an ECHO=0 unit sharing the same stimulus.
module tb_byte_calc_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_data_rdy;
    logic       tx_busy;
    logic [7:0] tx_data, tx_data0;
    logic       tx_data_rdy, tx_data_rdy0;
    logic [4:0] leds, leds0;
    logic       err, err0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int strobe_cyc = 0;
    int strobe0_cnt = 0;
    int err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    byte_calc_core #(.WIDTH(4), .ECHO(1)) dut (
        .clk12m(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_rdy(tx_data_rdy), .leds(leds), .err(err)
    );

    byte_calc_core #(.WIDTH(4), .ECHO(0)) dut0 (
        .clk12m(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_rdy(rx_data_rdy),
        .tx_busy(tx_busy), .tx_data(tx_data0), .tx_data_rdy(tx_data_rdy0), .leds(leds0), .err(err0)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output monitor: pops the scoreboard on every tx strobe, counts err pulses.
    always @(negedge clk) begin
        if (tx_data_rdy) begin
            strobe_cnt++;
            strobe_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got strobe with tx_data=%h, required no strobe", tx_data);
            end else begin
                exp_b = exp_q.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL tx_data: got %h, required %h", tx_data, exp_b);
                end
            end
        end
        if (err) err_cnt++;
        if (tx_data_rdy0) strobe0_cnt++;
    end

    task automatic send_byte(input logic [7:0] v);
        @(posedge clk); #1;
        rx_data     = v;
        rx_data_rdy = 1'b1;
        @(posedge clk); #1;
        rx_data_rdy = 1'b0;
        rx_data     = 8'h00;
    endtask

    task automatic send_calc(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                             input bit push, input logic [7:0] exp_tx);
        send_byte(a);
        send_byte(b);
        if (push) exp_q.push_back(exp_tx);
        send_byte(op);
    endtask

    task automatic wait_drain(input string name);
        int budget = 40;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_tx_timeout: %0d bytes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (leds !== 5'h00 || tx_data !== 8'h00 || tx_data_rdy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got leds=%b tx=%h rdy=%b err=%b, required all 0",
                     leds, tx_data, tx_data_rdy, err);
        end
        checks++;
        if (leds0 !== 5'h00 || tx_data0 !== 8'h00 || tx_data_rdy0 !== 1'b0 || err0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs_echo0: got leds=%b tx=%h rdy=%b err=%b, required all 0",
                     leds0, tx_data0, tx_data_rdy0, err0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        int acc;
        send_calc(8'd4, 8'd3, 8'h2B, 1'b1, 8'h07);
        acc = cyc;
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_0111) begin
            errors++;
            $display("FAIL add_4_3_leds: got %b, required 00111", leds);
        end
        checks++;
        if (leds0 !== 5'b0_0111) begin
            errors++;
            $display("FAIL add_4_3_leds_echo0: got %b, required 00111", leds0);
        end
        wait_drain("add_4_3");
        checks++;
        if (strobe_cyc !== acc + 1) begin
            errors++;
            $display("FAIL add_tx_latency: strobe at cycle %0d, required %0d", strobe_cyc, acc + 1);
        end
        send_calc(8'd4, 8'd4, 8'h2B, 1'b1, 8'h08);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_1000) begin
            errors++;
            $display("FAIL add_4_4_leds: got %b, required 01000", leds);
        end
        wait_drain("add_4_4");
        send_calc(8'd9, 8'd9, 8'h2B, 1'b1, 8'h12);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b1_0010) begin
            errors++;
            $display("FAIL add_9_9_carry: got %b, required 10010", leds);
        end
        wait_drain("add_9_9");
    endtask

    task automatic test_sub_logic();
        send_calc(8'd3, 8'd5, 8'h2D, 1'b1, 8'h1E);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b1_1110) begin
            errors++;
            $display("FAIL sub_3_5_borrow: got %b, required 11110", leds);
        end
        wait_drain("sub_3_5");
        send_calc(8'd12, 8'd10, 8'h26, 1'b1, 8'h08);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_1000) begin
            errors++;
            $display("FAIL and_12_10: got %b, required 01000", leds);
        end
        wait_drain("and_12_10");
        // Upper bits of operand bytes are ignored: 8'hFC and 8'hFA carry 12 and 10.
        send_calc(8'hFC, 8'hFA, 8'h7C, 1'b1, 8'h0E);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_1110) begin
            errors++;
            $display("FAIL or_12_10: got %b, required 01110", leds);
        end
        wait_drain("or_12_10");
    endtask

    task automatic test_bad_op();
        int e0 = err_cnt;
        int s0 = strobe_cnt;
        send_calc(8'd4, 8'd3, 8'h2A, 1'b0, 8'h00);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (err_cnt !== e0 + 1) begin
            errors++;
            $display("FAIL bad_op_err_cycles: got %0d err cycles, required 1", err_cnt - e0);
        end
        checks++;
        if (leds !== 5'b0_1110 || strobe_cnt !== s0) begin
            errors++;
            $display("FAIL bad_op_side_effect: got leds=%b strobes=%0d, required 01110 and 0",
                     leds, strobe_cnt - s0);
        end
        send_calc(8'd1, 8'd1, 8'h2B, 1'b1, 8'h02);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_0010) begin
            errors++;
            $display("FAIL bad_op_recover: got %b, required 00010", leds);
        end
        wait_drain("bad_op_recover");
    endtask

    task automatic test_busy();
        int e0 = err_cnt;
        int s0 = strobe_cnt;
        tx_busy = 1'b1;
        send_calc(8'd4, 8'd3, 8'h2B, 1'b1, 8'h07);
        repeat (8) @(posedge clk);
        #1;
        send_byte(8'h05);
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (strobe_cnt !== s0) begin
            errors++;
            $display("FAIL busy_hold: got %0d strobes while busy, required 0", strobe_cnt - s0);
        end
        checks++;
        if (err_cnt !== e0 + 1) begin
            errors++;
            $display("FAIL busy_overrun_err: got %0d err cycles, required 1", err_cnt - e0);
        end
        tx_busy = 1'b0;
        wait_drain("busy_release");
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (strobe_cnt !== s0 + 1) begin
            errors++;
            $display("FAIL busy_single_strobe: got %0d strobes, required 1", strobe_cnt - s0);
        end
    endtask

    task automatic test_esc();
        send_byte(8'd4);
        send_byte(8'h1B);
        send_calc(8'd2, 8'd1, 8'h2B, 1'b1, 8'h03);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_0011) begin
            errors++;
            $display("FAIL esc_restart: got %b, required 00011", leds);
        end
        wait_drain("esc");
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [4];
        int e0 = err_cnt;
        seq[0] = 8'd2; seq[1] = 8'd5; seq[2] = 8'h2B; seq[3] = 8'd9;
        exp_q.push_back(8'h07);
        @(posedge clk); #1;
        rx_data_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data = seq[i];
            @(posedge clk); #1;
        end
        rx_data_rdy = 1'b0;
        rx_data     = 8'h00;
        checks++;
        if (leds !== 5'b0_0111) begin
            errors++;
            $display("FAIL b2b_leds: got %b, required 00111", leds);
        end
        wait_drain("b2b");
        checks++;
        if (err_cnt !== e0 + 1) begin
            errors++;
            $display("FAIL b2b_compute_overrun: got %0d err cycles, required 1", err_cnt - e0);
        end
        send_calc(8'd1, 8'd1, 8'h2B, 1'b1, 8'h02);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_0010) begin
            errors++;
            $display("FAIL b2b_dropped_byte: got %b, required 00010", leds);
        end
        wait_drain("b2b_next");
    endtask

    task automatic test_reset_mid();
        int s0;
        send_byte(8'd4);
        send_byte(8'd3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (leds !== 5'h00 || tx_data !== 8'h00 || tx_data_rdy !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_seq: got leds=%b tx=%h rdy=%b err=%b, required all 0",
                     leds, tx_data, tx_data_rdy, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        send_calc(8'd1, 8'd2, 8'h2B, 1'b1, 8'h03);
        @(posedge clk); #1;
        checks++;
        if (leds !== 5'b0_0011) begin
            errors++;
            $display("FAIL reset_mid_recover: got %b, required 00011", leds);
        end
        wait_drain("reset_mid");
        tx_busy = 1'b1;
        send_calc(8'd1, 8'd1, 8'h2B, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        s0 = strobe_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (leds !== 5'h00 || tx_data_rdy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_tx: got leds=%b rdy=%b, required 00000 and 0", leds, tx_data_rdy);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        tx_busy = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (strobe_cnt !== s0) begin
            errors++;
            $display("FAIL reset_mid_tx_strobe: got %0d strobes, required 0", strobe_cnt - s0);
        end
    endtask

    task automatic test_echo0();
        checks++;
        if (strobe0_cnt !== 0) begin
            errors++;
            $display("FAIL echo0_tx: got %0d strobes, required 0", strobe0_cnt);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_data_rdy = 1'b0;
        tx_busy     = 1'b0;
        test_reset();
        test_add();
        test_sub_logic();
        test_bad_op();
        test_busy();
        test_esc();
        test_back_to_back();
        test_reset_mid();
        test_echo0();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
